// File: rtl/tspi_slave.sv
// Mode-0 SPI responder oversampled by clk: synchronised CSN/SCLK/MOSI, one-entry
// transmit holding register with dreq/valid handshake, rx words on a one-cycle strobe.
module tspi_slave #(
  parameter int SPI0_0 = 8,
  parameter int SYNC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSN,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  output logic              tx_dreq,
  input  logic              tx_valid,
  input  logic [SPI0_0-1:0] tx_data,
  output logic              tx_underrun,
  output logic [SPI0_0-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int CW = $clog2(SPI0_0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [SYNC-1:0]   csn_sync, sclk_sync, mosi_sync;
  logic              csn_d, sclk_d;
  logic              csn_s, sclk_s, mosi_s;
  logic              csn_fall, csn_rise, sclk_rise, sclk_fall;
  logic [SPI0_0-1:0] hold, tx_shift, rx_next;
  logic [SPI0_0-2:0] rx_shift;
  logic              hold_full;
  logic [CW-1:0]     bit_cnt;
  logic              load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_d     <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC-2:0], CSN};
      sclk_sync <= {sclk_sync[SYNC-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC-2:0], MOSI};
      csn_d     <= csn_sync[SYNC-1];
      sclk_d    <= sclk_sync[SYNC-1];
    end
  end

  assign csn_s     = csn_sync[SYNC-1];
  assign sclk_s    = sclk_sync[SYNC-1];
  assign mosi_s    = mosi_sync[SYNC-1];
  assign csn_fall  = csn_d & ~csn_s;
  assign csn_rise  = ~csn_d & csn_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign rx_next   = {rx_shift, mosi_s};

  // A load happens at frame start and on the SCLK fall that follows a completed word;
  // a CSN rise in the same cycle suppresses the SCLK-driven one.
  assign load = (state == IDLE && csn_fall) ||
                (state == ACTIVE && !csn_rise && sclk_fall && bit_cnt == '0);

  assign tx_dreq = ~hold_full;
  assign miso_oe = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      MISO        <= 1'b0;
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_valid    <= 1'b0;
      MISO        <= (state == ACTIVE) ? tx_shift[SPI0_0-1] : 1'b0;

      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end
      // Write acceptance uses the pre-load state, so it never bypasses into tx_shift.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (csn_fall) begin
            state <= ACTIVE;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (csn_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next[SPI0_0-2:0];
            if (bit_cnt == CW'(SPI0_0 - 1)) begin
              bit_cnt  <= '0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            tx_shift <= tx_shift << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tspi_slave.sv
// Randomised bench for tspi_slave: a transaction-level model of the hold register
// predicts MISO words, underruns and received words; a monitor scores rx_valid.
module tb_tspi_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CSN = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic       MISO, miso_oe, tx_dreq, tx_underrun, rx_valid, busy;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;

  tspi_slave #(.SPI0_0(8), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .miso_oe(miso_oe), .tx_dreq(tx_dreq), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int under_cnt = 0, exp_under = 0;
  logic       mfull = 1'b0;
  logic [7:0] mhold = '0, last_rx = '0;
  logic [7:0] tx_q[$], rx_q[$];
  logic [7:0] mosi_w[4], wr_d[4];
  logic       wr_en[4];
  logic       start_wr = 1'b0;
  logic [7:0] start_wd = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every rx_valid must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_underrun) under_cnt++;
      if (rx_valid) begin
        if (rx_q.size() == 0) check("rx_unexpected", {24'h0, rx_data}, 32'hdead);
        else check("rx_word", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
      end
    end
  end

  function automatic void model_load();
    if (mfull) begin
      tx_q.push_back(mhold);
      mfull = 1'b0;
    end else begin
      tx_q.push_back(8'h00);
      exp_under++;
    end
  endfunction

  task automatic write_word(input logic [7:0] d);
    @(negedge clk);
    check("tx_dreq_wr", {31'h0, tx_dreq}, {31'h0, !mfull});
    tx_valid = 1'b1; tx_data = d;
    if (!mfull) begin mhold = d; mfull = 1'b1; end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_miso", {31'h0, MISO}, 0);
    check("rst_oe", {31'h0, miso_oe}, 0);
    check("rst_dreq", {31'h0, tx_dreq}, 1);
    check("rst_under", {31'h0, tx_underrun}, 0);
    check("rst_rxd", {24'h0, rx_data}, 0);
    check("rst_rxv", {31'h0, rx_valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
  endtask

  // One CSN-framed transfer of nbits; only complete words are checked on MISO.
  task automatic frame(input int nbits, input int hp);
    logic [7:0] got;
    logic acc;
    int b, w;
    got = '0;
    @(negedge clk);
    CSN = 1'b0;
    if (start_wr) begin
      repeat (2) @(negedge clk);
      tx_valid = 1'b1; tx_data = start_wd;
      acc = !mfull;
      model_load();
      if (acc) begin mhold = start_wd; mfull = 1'b1; end
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (6) @(negedge clk);
    end else begin
      model_load();
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      b = 7 - (i % 8);
      w = i / 8;
      MOSI = mosi_w[w][b];
      repeat (hp) @(negedge clk);
      got[b] = MISO;
      if (b == 7) begin
        check("tx_dreq_word", {31'h0, tx_dreq}, {31'h0, !mfull});
        check("oe_active", {30'h0, miso_oe, busy}, 32'h3);
      end
      SCLK = 1'b1;
      if (b == 0) begin
        rx_q.push_back(mosi_w[w]);
        last_rx = mosi_w[w];
      end
      if (b == 4 && wr_en[w]) begin
        write_word(wr_d[w]);
        repeat (hp - 2) @(negedge clk);
      end else begin
        repeat (hp) @(negedge clk);
      end
      SCLK = 1'b0;
      if (b == 0) begin
        model_load();
        if (tx_q.size() == 0) check("tx_q_empty", 0, 1);
        else check("miso_word", {24'h0, got}, {24'h0, tx_q.pop_front()});
      end
    end
    repeat (hp) @(negedge clk);
    CSN = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
    tx_q.delete();
    check("idle_oe", {30'h0, miso_oe, busy}, 0);
    check("underruns", under_cnt, exp_under);
    check("rx_held", {24'h0, rx_data}, {24'h0, last_rx});
    for (int k = 0; k < 4; k++) wr_en[k] = 1'b0;
    start_wr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin wr_en[k] = 1'b0; wr_d[k] = '0; mosi_w[k] = '0; end
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Preloaded single word.
    write_word(8'hA5);
    mosi_w[0] = 8'h3C;
    frame(8, 6);

    // Two words, second written while the first shifts.
    write_word(8'h12);
    mosi_w[0] = 8'hF0; mosi_w[1] = 8'h0F;
    wr_en[0] = 1'b1; wr_d[0] = 8'h34;
    frame(16, 6);

    // Empty hold at frame start, with a write in the load cycle.
    start_wr = 1'b1; start_wd = 8'h9C;
    mosi_w[0] = 8'hC3;
    frame(8, 6);

    // Partial frame discarded, then a full one.
    mosi_w[0] = 8'hFF;
    frame(5, 6);
    mosi_w[0] = 8'h81;
    frame(8, 6);

    // Reset in the middle of a word.
    @(negedge clk);
    CSN = 1'b0;
    model_load();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      MOSI = i[0];
      repeat (6) @(negedge clk);
      SCLK = 1'b1;
      repeat (6) @(negedge clk);
      SCLK = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    CSN = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    mfull = 1'b0; last_rx = '0;
    tx_q.delete();
    repeat (8) @(negedge clk);
    mosi_w[0] = 8'h55;
    frame(8, 6);

    // Write while full is dropped.
    write_word(8'h66);
    write_word(8'h77);
    mosi_w[0] = 8'h5A;
    frame(8, 7);

    // Random frames.
    for (int n = 0; n < 20; n++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        mosi_w[k] = 8'($urandom);
        wr_en[k]  = 1'($urandom_range(0, 1));
        wr_d[k]   = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) write_word(8'($urandom));
      start_wr = ($urandom_range(0, 3) == 0);
      start_wd = 8'($urandom);
      frame(nw * 8, $urandom_range(6, 8));
    end

    repeat (10) @(negedge clk);
    check("rx_pending", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
